// File: rtl/disp_src_mux.sv
`default_nettype none
// ============================================================================
// Module   : disp_src_mux
// Brief    : Registered N-channel BCD digit-group selector with auto-scan,
//            blink/blank and invalid-select guard for the display path.
// Revision : 1.0
// ============================================================================
module disp_src_mux #(
    parameter int             NCH        = 4,
    parameter int             NDIG       = 2,
    parameter int             DW         = 4,
    parameter int             SELW       = 2,
    parameter int             DWELL      = 5,
    parameter logic [DW-1:0]  BLANK_CODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    input  logic [NCH*NDIG*DW-1:0] din,
    input  logic                   blink_en,
    output logic [NDIG*DW-1:0]     s_out,
    output logic [SELW-1:0]        cur_ch,
    output logic                   ch_chg,
    output logic                   sel_err
);

    localparam int               c_grp_w      = NDIG * DW;
    localparam int               c_nsel       = 2 ** SELW;
    localparam logic [SELW:0]    c_nch        = (SELW+1)'(NCH);
    localparam logic [SELW-1:0]  c_last_ch    = SELW'(NCH - 1);
    localparam logic [SELW-1:0]  c_one_ch     = SELW'(1);
    localparam logic [7:0]       c_dwell_last = 8'(DWELL - 1);

    // Full 2**SELW table so any select value indexes in range; unused slots read zero.
    logic [c_grp_w-1:0] w_grp [c_nsel];

    generate
        for (genvar c = 0; c < c_nsel; c++) begin : g_grp
            if (c < NCH) begin : g_used
                assign w_grp[c] = din[c*c_grp_w +: c_grp_w];
            end else begin : g_unused
                assign w_grp[c] = '0;
            end
        end
    endgenerate

    logic [SELW-1:0]    r_cur_ch;
    logic [7:0]         r_cnt;
    logic               r_phase;
    logic [c_grp_w-1:0] r_s_out;
    logic               r_ch_chg;
    logic               r_sel_err;

    logic               w_sel_ok;
    logic [SELW-1:0]    w_ch_next;
    logic [7:0]         w_cnt_next;
    logic               w_err_next;
    logic               w_phase_next;
    logic [c_grp_w-1:0] w_s_out_next;

    always_comb begin
        w_sel_ok   = ({1'b0, sel} < c_nch);
        w_ch_next  = r_cur_ch;
        w_cnt_next = r_cnt;
        w_err_next = 1'b0;
        if (!mode) begin
            w_cnt_next = '0;
            if (w_sel_ok) begin
                w_ch_next = sel;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (tick) begin
            if (r_cnt >= c_dwell_last) begin
                w_cnt_next = '0;
                w_ch_next  = (r_cur_ch == c_last_ch) ? '0 : r_cur_ch + c_one_ch;
            end else begin
                w_cnt_next = r_cnt + 8'd1;
            end
        end
        // Output is built from the post-edge channel and phase so simultaneous
        // advance and blink toggle land together.
        w_phase_next = blink_en & (r_phase ^ tick);
        w_s_out_next = w_phase_next ? {NDIG{BLANK_CODE}} : w_grp[w_ch_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_ch  <= '0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_s_out   <= '0;
            r_ch_chg  <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_cur_ch  <= w_ch_next;
            r_cnt     <= w_cnt_next;
            r_phase   <= w_phase_next;
            r_s_out   <= w_s_out_next;
            r_ch_chg  <= (w_ch_next != r_cur_ch);
            r_sel_err <= w_err_next;
        end
    end

    assign s_out   = r_s_out;
    assign cur_ch  = r_cur_ch;
    assign ch_chg  = r_ch_chg;
    assign sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: doc/disp_src_mux.md
Name: disp_src_mux

Overview:
- Registered N-channel BCD digit-group selector for the D-Clock display path.
- Successor to the two-source digit-pair mux. It picks one of NCH digit groups (time, alarm, timer, date, ...) for the display driver.
- Adds an auto-scan mode that steps through channels on a 1 Hz tick, a blink/blank function and an invalid-select guard.
- Sits between the counter/borrow logic and the 7-segment decoder.

Parameters:
NCH, 4, number of source channels (2..16)
NDIG, 2, digits per channel
DW, 4, bits per digit (BCD)
SELW, 2, select width; must satisfy 2**SELW >= NCH
DWELL, 5, tick count spent on each channel in auto-scan mode (1..255)
BLANK_CODE, 4'hF, digit code the decoder renders as dark

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous reset, active-high
tick  in  1  one-cycle 1 Hz enable pulse
mode  in  1  0 = manual select, 1 = auto-scan
sel  in  SELW  manual channel select
din  in  NCH*NDIG*DW  channel c occupies bits [(c+1)*NDIG*DW-1 : c*NDIG*DW]
blink_en  in  1  blink the output at 0.5 Hz (toggle per tick)
s_out  out  NDIG*DW  selected digit group, registered
cur_ch  out  SELW  channel currently driving s_out
ch_chg  out  1  one-cycle pulse when cur_ch changes
sel_err  out  1  registered; high while mode=0 and sel >= NCH

Behaviour:
- Reset (rst=1 at posedge):
  - s_out=0, cur_ch=0, ch_chg=0, sel_err=0.
  - Dwell counter=0, blink phase=0 (visible).
  - rst overrides every other input; reset mid-scan restarts at channel 0.
- Latency: s_out reflects din of cur_ch with one clock of latency. din changes on channel cur_ch appear on s_out the next posedge.
- Manual mode (mode=0):
  - sel < NCH: cur_ch <= sel on the next posedge.
  - sel >= NCH: cur_ch holds its previous value and sel_err=1 on that posedge. sel_err clears on the first posedge with a valid sel.
  - Dwell counter is held at 0.
- Auto-scan mode (mode=1):
  - sel is ignored and sel_err=0.
  - Each tick increments the dwell counter.
  - On the tick where the counter equals DWELL-1: counter <= 0 and cur_ch <= cur_ch+1.
  - Wrap: cur_ch=NCH-1 advances to 0. Values >= NCH are never produced, including when NCH is not a power of two.
- Mode transitions:
  - 0->1: scan starts from the current cur_ch with the counter at 0.
  - 1->0: cur_ch <= sel on the same posedge (valid-sel rules apply).
- ch_chg: 1 for exactly one cycle, on the cycle after cur_ch takes a new value. Re-selecting the same channel produces no pulse.
- Blink:
  - When blink_en=1, the blink phase toggles on every tick.
  - Phase=1 forces every digit of s_out to BLANK_CODE.
  - When blink_en=0, the phase is forced to 0 on the next posedge, so the output is visible.
  - Blanking affects s_out only; cur_ch and ch_chg are unaffected.
- Simultaneous events: if tick occurs on the same posedge as a channel advance and a blink toggle, both take effect together. The new channel's data is shown, blanked if the new phase=1.
- Width: NDIG*DW slice extraction only; no arithmetic on digit data.

Test Plan:
1. Reset and manual select:
   - Stimulus: din = ch3 8'h59, ch2 8'h30, ch1 8'h12, ch0 8'h07; rst pulse; mode=0, sel=2.
   - Required: s_out=8'h30 and cur_ch=2 one cycle after sel applied; ch_chg pulses once.
2. Auto-scan wrap:
   - Stimulus: mode=1 from cur_ch=2, DWELL=5, 20 ticks.
   - Required: cur_ch sequence 2->3->0->1->2, advancing every 5th tick; 4 ch_chg pulses; s_out follows 30,59,07,12,30.
3. Invalid select with NCH=3, SELW=2:
   - Stimulus: sel=3.
   - Required: cur_ch holds, sel_err=1, no ch_chg. Then sel=1: sel_err=0, cur_ch=1.
4. Blink:
   - Stimulus: blink_en=1 on ch0 (8'h07); 4 ticks.
   - Required: s_out alternates 8'hFF / 8'h07 per tick. Dropping blink_en during the blank phase gives 8'h07 on the next posedge.
5. Reset mid-scan:
   - Stimulus: mode=1, cur_ch=3, counter=3; assert rst with tick high on the same cycle.
   - Required: all outputs 0, cur_ch=0. Scan resumes from 0, and the first advance occurs after 5 further ticks.
6. Mode switch:
   - Stimulus: in auto mode at cur_ch=1; set mode=0 with sel=3.
   - Required: cur_ch=3 on the next posedge, ch_chg pulse; later ticks do not advance cur_ch.
